// File: rtl/board_input_pkg.sv
// board_input_pkg: shared defaults and width helper for board input conditioning
package board_input_pkg;
  localparam int DB_CYCLES_DEFAULT = 12000;
  localparam int RST_HOLD_DEFAULT = 16;
  localparam int NBTN_MAX = 8;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/btn_debounce_ch.sv
// btn_debounce_ch: one channel of 2-flop sync, debounce counter and edge pulses
// Edge flops exist only with BOARD_INPUT_COND_EDGE_EN defined; otherwise edges tie to 0.
module btn_debounce_ch
  import board_input_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = clog2(DB_CYCLES + 1);
  logic meta_q, sync_q, lvl_q, lvl_d, flip;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    flip = (sync_q != lvl_q) && (cnt_q == CW'(DB_CYCLES - 1));
    cnt_d = (sync_q == lvl_q || flip) ? '0 : cnt_q + 1'b1;
    lvl_d = flip ? sync_q : lvl_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= IDLE_VAL;
      sync_q <= IDLE_VAL;
      lvl_q <= IDLE_VAL;
      cnt_q <= '0;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end
  assign btn_o = lvl_q;
`ifdef BOARD_INPUT_COND_EDGE_EN
  logic rise_q, fall_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= flip & sync_q;
      fall_q <= flip & ~sync_q;
    end
  end
  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = 1'b0;
  assign fall_o = 1'b0;
`endif
endmodule

// File: rtl/board_input_cond.sv
// board_input_cond: debounced board buttons plus stretched core reset
// Edge pulse outputs are built only with BOARD_INPUT_COND_EDGE_EN defined.
module board_input_cond
  import board_input_pkg::*;
#(
  parameter int NBTN = 2,
  parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
  parameter int RST_HOLD = RST_HOLD_DEFAULT,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NBTN-1:0] btn_i,
  output logic [NBTN-1:0] btn_o,
  output logic [NBTN-1:0] btn_rise,
  output logic [NBTN-1:0] btn_fall,
  output logic            core_rst_n
);
  genvar k;
  generate
    for (k = 0; k < NBTN; k++) begin : g_ch
      btn_debounce_ch #(.DB_CYCLES(DB_CYCLES), .IDLE_VAL(IDLE_VAL)) u_ch (
        .clk(clk), .rst_n(rst_n), .btn_i(btn_i[k]),
        .btn_o(btn_o[k]), .rise_o(btn_rise[k]), .fall_o(btn_fall[k])
      );
    end
  endgenerate
  // Saturating hold counter: core leaves reset on the RST_HOLD-th edge after release.
  logic [7:0] hold_q, hold_d;
  logic core_q, core_d, hold_done;
  always_comb begin
    hold_done = (hold_q == 8'(RST_HOLD - 1));
    hold_d = hold_done ? hold_q : hold_q + 8'd1;
    core_d = core_q | hold_done;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= '0;
      core_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      core_q <= core_d;
    end
  end
  assign core_rst_n = core_q;
endmodule

// File: tb/tb_board_input_cond.sv
// tb_board_input_cond: randomized scoreboard bench against a run-length debounce model
module tb_board_input_cond;
  localparam int NB = 2, DB = 8, RH = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NB-1:0] btn_i = '0, btn_o, btn_rise, btn_fall;
  logic core_rst_n;
  always #5 clk = ~clk;
  board_input_cond #(.NBTN(NB), .DB_CYCLES(DB), .RST_HOLD(RH), .IDLE_VAL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_i), .btn_o(btn_o),
    .btn_rise(btn_rise), .btn_fall(btn_fall), .core_rst_n(core_rst_n)
  );
  typedef struct packed {logic [NB-1:0] o, r, f; logic c;} exp_t;
  exp_t exp_q[$];
  int tests = 0, fails = 0;
  logic [NB-1:0] p1, p2, m_out, m_r, m_f;
  int run[NB];
  int since;
  task automatic model_reset();
    p1 = '0; p2 = '0; m_out = '0; m_r = '0; m_f = '0; since = 0;
    for (int k = 0; k < NB; k++) run[k] = 0;
  endtask
  // A level reaches the output once it has differed from it for DB consecutive synchronized samples.
  task automatic model_edge();
    m_r = '0; m_f = '0;
    if (!rst_n) return;
    for (int k = 0; k < NB; k++) begin
      if (p2[k] != m_out[k]) begin
        run[k]++;
        if (run[k] == DB) begin
          m_out[k] = p2[k];
          if (p2[k]) m_r[k] = 1'b1; else m_f[k] = 1'b1;
          run[k] = 0;
        end
      end else run[k] = 0;
    end
    p2 = p1; p1 = btn_i;
    if (since < RH) since++;
  endtask
  task automatic step(input logic r, input logic [NB-1:0] b);
    exp_t e;
    @(posedge clk);
    model_edge();
    #1;
    rst_n = r; btn_i = b;
    if (!r) model_reset();
    e.o = m_out;
`ifdef BOARD_INPUT_COND_EDGE_EN
    e.r = m_r; e.f = m_f;
`else
    e.r = '0; e.f = '0;
`endif
    e.c = (since >= RH);
    exp_q.push_back(e);
  endtask
  task automatic hold(input logic r, input logic [NB-1:0] b, input int n);
    for (int i = 0; i < n; i++) step(r, b);
  endtask
  task automatic check_int(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({btn_o, btn_rise, btn_fall, core_rst_n} !== e) begin
        fails++;
        $display("FAIL cyc t=%0t got o=%b r=%b f=%b c=%b want o=%b r=%b f=%b c=%b",
                 $time, btn_o, btn_rise, btn_fall, core_rst_n, e.o, e.r, e.f, e.c);
      end
    end
  end
  task automatic core_latency(input string name);
    int n;
    n = 0;
    step(1'b1, btn_i);
    while (!core_rst_n && n < 20) begin
      step(1'b1, btn_i);
      n++;
    end
    check_int(name, n, RH);
  endtask
  initial begin
    int n;
    logic [NB-1:0] v;
    model_reset();
    hold(1'b0, '0, 3);
    core_latency("core_release");
    hold(1'b1, 2'b00, 4);
    step(1'b1, 2'b01);
    n = 0;
    while (!btn_o[0] && n < 40) begin
      step(1'b1, 2'b01);
      n++;
    end
    check_int("btn0_latency", n, DB + 2);
    hold(1'b1, 2'b01, 5);
    for (int i = 0; i < 2; i++) begin
      hold(1'b1, 2'b11, 3);
      hold(1'b1, 2'b01, 3);
    end
    hold(1'b1, 2'b11, 15);
    hold(1'b1, 2'b10, 5);
    hold(1'b1, 2'b11, 15);
    for (int i = 0; i < 40; i++) begin
      v = NB'($urandom);
      hold(1'b1, v, $urandom_range(1, 12));
    end
    hold(1'b1, 2'b00, 6);
    hold(1'b0, 2'b00, 2);
    core_latency("core_rerelease");
    for (int i = 0; i < 30; i++) begin
      v = NB'($urandom);
      hold(($urandom_range(0, 19) != 0), v, $urandom_range(1, 14));
    end
    hold(1'b1, btn_i, 20);
    @(negedge clk);
    @(negedge clk);
    check_int("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/board_input_cond.md
BOARD_INPUT_COND -- requirements
Module: board_input_cond

Interface
REQ-001 SHALL have parameter NBTN, default 2: number of button/switch input channels (1..8).
REQ-002 SHALL have parameter DB_CYCLES, default 12000: debounce stability window in clk cycles, 1 ms at 12 MHz (range 1..2^20).
REQ-003 SHALL have parameter RST_HOLD, default 16: cycles core_rst_n stays low after rst_n release (range 2..255).
REQ-004 SHALL have parameter IDLE_VAL, default 0: released level of every button, and the reset value of the synchronizer and btn_o.
REQ-005 SHALL have port clk, input, 1 bit: single clock; MMCM output after BUFG.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset (MMCM LOCKED).
REQ-007 SHALL have port btn_i, input, NBTN bits: raw asynchronous board buttons/pins.
REQ-008 SHALL have port btn_o, output, NBTN bits: synchronized, debounced levels, driving fpga_core gpio_i.
REQ-009 SHALL have port btn_rise, output, NBTN bits: one-cycle pulse on a 0->1 change of btn_o.
REQ-010 SHALL have port btn_fall, output, NBTN bits: one-cycle pulse on a 1->0 change of btn_o.
REQ-011 SHALL have port core_rst_n, output, 1 bit: stretched reset to the core; asynchronous assert, synchronous deassert.

Function
REQ-012 Each channel SHALL pass btn_i through a 2-flop synchronizer; sync[k] is the second-flop output.
REQ-013 Each channel SHALL keep a counter of width clog2(DB_CYCLES+1) that clears on any cycle where sync[k]==btn_o[k].
REQ-014 The counter SHALL increment on every cycle where sync[k]!=btn_o[k].
REQ-015 On the edge where the counter equals DB_CYCLES-1 and sync[k]!=btn_o[k], btn_o[k] SHALL take sync[k] and the counter SHALL clear.
REQ-016 A new stable btn_i level SHALL therefore appear on btn_o exactly DB_CYCLES+2 cycles after it is first sampled.
REQ-017 Any input pulse or bounce shorter than DB_CYCLES synchronized cycles SHALL leave btn_o unchanged and restart the window.
REQ-018 btn_rise[k]/btn_fall[k] SHALL be registered and high only in the first cycle that btn_o[k] shows its new value.
REQ-019 btn_rise and btn_fall SHALL never both be high on one channel, and SHALL be 0 in every other cycle.
REQ-020 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each complete per REQ-016.
REQ-021 With DB_CYCLES=1, btn_o SHALL follow sync with exactly one cycle of delay.
REQ-022 The reset stretcher SHALL hold core_rst_n low for exactly RST_HOLD rising clk edges after rst_n deasserts, then drive it high.
REQ-023 The stretcher counter SHALL saturate, keeping core_rst_n high until the next rst_n assertion.

Reset
REQ-024 While rst_n=0, outputs SHALL be: synchronizer flops and btn_o = {NBTN{IDLE_VAL}}; counters 0; btn_rise = btn_fall = 0; core_rst_n = 0.
REQ-025 rst_n assertion mid-debounce or mid-stretch SHALL abort the operation immediately (asynchronously) and emit no pulse.
REQ-026 The first edge after reset release SHALL NOT produce a rise/fall pulse, even if btn_i differs from IDLE_VAL; that difference is debounced normally.

Configuration
REQ-027 With macro BOARD_INPUT_COND_EDGE_EN defined, btn_rise/btn_fall logic SHALL be built per REQ-018/019.
REQ-028 Without BOARD_INPUT_COND_EDGE_EN, btn_rise and btn_fall SHALL be tied to 0, and no edge registers SHALL be inferred.
REQ-029 Debounce and reset behaviour SHALL be identical whether or not the macro is defined.

Structure
REQ-030 A shared package board_input_pkg SHALL hold DB_CYCLES_DEFAULT, RST_HOLD_DEFAULT, the NBTN maximum, and a clog2 helper function.
REQ-031 A per-channel sub-module btn_debounce_ch SHALL contain the synchronizer, counter, btn_o flop and edge flops, instantiated NBTN times in a generate loop.
REQ-032 The reset stretcher SHALL live in the top of board_input_cond.

Verification (bench: DB_CYCLES=8, RST_HOLD=4, NBTN=2, IDLE_VAL=0)
REQ-033 Reset release, btn_i=00 -> core_rst_n high on the 4th edge after release; btn_o=00; no pulses.
REQ-034 btn_i[0] steps 0->1 and holds -> btn_o[0]=1 exactly 10 cycles later; btn_rise[0] high for that single cycle only.
REQ-035 btn_i[1] bounces 1,0,1,0 (3-cycle segments) then holds 1 -> btn_o[1] rises 10 cycles after the final edge; exactly one btn_rise[1].
REQ-036 btn_i[0] 1->0 glitch of 5 cycles while btn_o[0]=1 -> btn_o[0] stays 1; no btn_fall.
REQ-037 rst_n pulsed low at cycle 6 of a debounce window -> btn_o=00 and core_rst_n=0 immediately; after release, REQ-033 timing repeats.
REQ-038 Build without BOARD_INPUT_COND_EDGE_EN and rerun REQ-034 -> same btn_o timing; btn_rise/btn_fall constantly 0.
